// File: rtl/uop_issue_scheduler_pkg.sv
// Shared definitions for the uop issue scheduler.
// Holds the micro-op field layout (mirrors micro_operations.v), the class and
// operand-type encodings, the unit-select encodings and a class->unit helper.
package uop_issue_scheduler_pkg;

    // Field layout of a decoded uop
    localparam int unsigned UOP_W_DEF           = 64;
    localparam int unsigned REG_IDX_W           = 4;
    localparam int unsigned UOP_VALID_B         = 0;
    localparam int unsigned UOP_CLASS_LSB       = 1;
    localparam int unsigned UOP_CLASS_W         = 4;
    localparam int unsigned UOP_I_TYPE_LSB      = 5;
    localparam int unsigned UOP_I_TYPE_W        = 3;
    localparam int unsigned UOP_I_DST_0_LSB     = 8;
    localparam int unsigned UOP_I_DST_0_VALID_B = 12;
    localparam int unsigned UOP_I_SRC_0_LSB     = 13;
    localparam int unsigned UOP_I_SRC_1_LSB     = 17;
    localparam int unsigned UOP_I_SRC_2_LSB     = 21;

    // Uop class encodings
    localparam logic [UOP_CLASS_W-1:0] UOP_INTEGER   = 4'd1;
    localparam logic [UOP_CLASS_W-1:0] UOP_INTEGER_M = 4'd2;
    localparam logic [UOP_CLASS_W-1:0] UOP_LOAD      = 4'd3;
    localparam logic [UOP_CLASS_W-1:0] UOP_STORE     = 4'd4;

    // Operand type encodings
    localparam logic [UOP_I_TYPE_W-1:0] UOP_REG = 3'd0;
    localparam logic [UOP_I_TYPE_W-1:0] UOP_IMM = 3'd1;

    // Unit-select encodings
    typedef enum logic [1:0] {
        UNIT_NONE = 2'd0,
        UNIT_INT  = 2'd1,
        UNIT_INTM = 2'd2,
        UNIT_LSU  = 2'd3
    } unit_e;

    // Decoded view of the fields the scheduler looks at
    typedef struct packed {
        logic [UOP_CLASS_W-1:0]  cls;
        logic [UOP_I_TYPE_W-1:0] itype;
        logic [REG_IDX_W-1:0]    dst;
        logic                    dst_v;
        logic [REG_IDX_W-1:0]    src0;
        logic [REG_IDX_W-1:0]    src1;
        logic [REG_IDX_W-1:0]    src2;
    } uop_head_t;

    // Map a uop class to its execution unit; unknown classes get UNIT_NONE
    function automatic unit_e uop_unit(input logic [UOP_CLASS_W-1:0] cls);
        unit_e u;
        u = UNIT_NONE;
        case (cls)
            UOP_INTEGER:         u = UNIT_INT;
            UOP_INTEGER_M:       u = UNIT_INTM;
            UOP_LOAD, UOP_STORE: u = UNIT_LSU;
            default:             u = UNIT_NONE;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/uop_issue_scheduler_fifo.sv
// uop_fifo: parameterised synchronous FIFO with flush.
// Ports: clk, rst (sync, active-high), flush, push/push_data, pop/pop_data
// (registered head), full, empty, count (occupancy).
module uop_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; pointers define what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uop_issue_scheduler.sv
// uop_issue_scheduler: in-order issue of decoded uops to int / intm / lsu units.
// Ports: clk, rst (sync, active-high); uop_valid_i/uop_i/uop_ready_o decode side;
// flush_i; wb_valid_i/wb_dst_i writeback; intm_ready_i, lsu_ready_i unit ready;
// iss_uop_o shared issue bus, int/intm/lsu_valid_o, stall_hazard_o, count_o.
module uop_issue_scheduler
    import uop_issue_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned UOP_W = 64,
    parameter int unsigned NREG  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   uop_valid_i,
    input  logic [UOP_W-1:0]       uop_i,
    output logic                   uop_ready_o,
    input  logic                   flush_i,
    input  logic                   wb_valid_i,
    input  logic [REG_IDX_W-1:0]   wb_dst_i,
    input  logic                   intm_ready_i,
    input  logic                   lsu_ready_i,
    output logic [UOP_W-1:0]       iss_uop_o,
    output logic                   int_valid_o,
    output logic                   intm_valid_o,
    output logic                   lsu_valid_o,
    output logic                   stall_hazard_o,
    output logic [$clog2(DEPTH):0] count_o
);
    logic [UOP_W-1:0] head;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    logic             head_live;
    logic             hazard;
    logic             set_busy;
    logic [NREG-1:0]  busy;
    logic [NREG-1:0]  busy_nxt;
    uop_head_t        hf;
    unit_e            unit;

    // Bubbles (valid bit clear) are accepted but never stored
    assign push        = uop_valid_i && !full && uop_i[UOP_VALID_B] && !flush_i;
    assign uop_ready_o = !full;

    uop_fifo #(
        .DEPTH (DEPTH),
        .W     (UOP_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_i),
        .push      (push),
        .push_data (uop_i),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count_o)
    );

    // Decode the head fields the scheduler needs
    always_comb begin
        hf       = '0;
        hf.cls   = head[UOP_CLASS_LSB +: UOP_CLASS_W];
        hf.itype = head[UOP_I_TYPE_LSB +: UOP_I_TYPE_W];
        hf.dst   = head[UOP_I_DST_0_LSB +: REG_IDX_W];
        hf.dst_v = head[UOP_I_DST_0_VALID_B];
        hf.src0  = head[UOP_I_SRC_0_LSB +: REG_IDX_W];
        hf.src1  = head[UOP_I_SRC_1_LSB +: REG_IDX_W];
        hf.src2  = head[UOP_I_SRC_2_LSB +: REG_IDX_W];
    end

    assign unit = uop_unit(hf.cls);

    // RAW on checked sources plus WAW on the destination
    always_comb begin
        hazard = busy[hf.src0];
        if (hf.itype != UOP_IMM) hazard = hazard | busy[hf.src1] | busy[hf.src2];
        if (hf.dst_v)            hazard = hazard | busy[hf.dst];
    end

    // Valids present the head whenever it is clear to go; transfer needs unit ready
    assign head_live      = !empty && !flush_i && !rst;
    assign int_valid_o    = head_live && !hazard && (unit == UNIT_INT);
    assign intm_valid_o   = head_live && !hazard && (unit == UNIT_INTM);
    assign lsu_valid_o    = head_live && !hazard && (unit == UNIT_LSU);
    assign drop           = head_live && (unit == UNIT_NONE);
    assign stall_hazard_o = !empty && !rst && (unit != UNIT_NONE) && hazard;
    assign iss_uop_o      = head;

    assign pop = int_valid_o
               | (intm_valid_o && intm_ready_i)
               | (lsu_valid_o && lsu_ready_i)
               | drop;
    assign set_busy = pop && !drop && hf.dst_v;

    // Writeback clears first so a same-cycle issue set wins
    always_comb begin
        busy_nxt = busy;
        if (wb_valid_i) busy_nxt[wb_dst_i] = 1'b0;
        if (set_busy)   busy_nxt[hf.dst]   = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) busy <= '0;
        else                busy <= busy_nxt;
    end

endmodule
